reg_file_wb: RTL

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/reg_file_wb.sv | 68 ++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// Register file with a one-entry writeback stage: writes are captured on one edge and committed on the next.
// Reads are combinational and forward the pending entry so the newest value is always visible.
module reg_file_wb #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   output logic              PENDING
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_reg [DEPTH];
   logic [DATA_W-1:0] wb_data_reg;
   logic [ADDR_W-1:0] wb_addr_reg;
   logic              wb_valid_reg;

   // Writeback stage: a new capture and the commit of the previous entry share an edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wb_data_reg  <= '0;
         wb_addr_reg  <= '0;
         wb_valid_reg <= 1'b0;
      end else if (WRITE) begin
         wb_data_reg  <= IN;
         wb_addr_reg  <= INADDRESS;
         wb_valid_reg <= 1'b1;
      end else begin
         wb_valid_reg <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               regs_reg[gi] <= '0;
            end else if (wb_valid_reg && (wb_addr_reg == ADDR_W'(gi))) begin
               regs_reg[gi] <= wb_data_reg;
            end
         end
      end
   endgenerate

   // Each port forwards independently from the pending entry.
   always_comb begin
      OUT1 = regs_reg[OUT1ADDRESS];
      OUT2 = regs_reg[OUT2ADDRESS];
      if (wb_valid_reg && (OUT1ADDRESS == wb_addr_reg)) begin
         OUT1 = wb_data_reg;
      end
      if (wb_valid_reg && (OUT2ADDRESS == wb_addr_reg)) begin
         OUT2 = wb_data_reg;
      end
   end

   assign PENDING = wb_valid_reg;

endmodule
